// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
// Debounced 10-key digit keypad feeding a three-digit M:SS time entry.
// A single key held stable for DEBOUNCE_CYCLES consecutive edges after
// detection is accepted once. The digits then shift left (mins <= tens,
// tens <= secs, secs <= digit). The shift is refused when it would put a
// value above 5 into the tens-of-seconds place.
// A key must be fully released, debounced the same way, before another
// key can be accepted.
// Optional feature: define KEYPAD_ERR_EN to add the key_err output. It
// flags refused shifts and multi-key presses seen while idle.
// -----------------------------------------------------------------------------
module keypad_encoder #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] keys,
    input  logic       clear,
    input  logic       entry_en,
    output logic [3:0] secs,
    output logic [3:0] tens,
    output logic [3:0] mins,
    output logic       key_valid,
    output logic [3:0] key_code
`ifdef KEYPAD_ERR_EN
    ,
    output logic       key_err
`endif
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    // Number of key lines currently high
    function automatic logic [3:0] count_ones(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 10; k++) begin
            n = n + {3'd0, v[k]};
        end
        return n;
    endfunction

    // Binary value of the highest set line (pattern is one-hot when used)
    function automatic logic [3:0] encode_key(input logic [9:0] v);
        logic [3:0] code;
        code = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (v[k]) begin
                code = 4'(k);
            end
        end
        return code;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [9:0]       cand_r, cand_s;

    logic [3:0] secs_r, tens_r, mins_r;
    logic [3:0] secs_s, tens_s, mins_s;
    logic       key_valid_r;
    logic [3:0] key_code_r, key_code_s;

    logic [3:0] ones_s;
    logic       single_s;
    logic       multi_s;
    logic       accept_s;
    logic       shift_ok_s;
    logic [3:0] cand_code_s;

    assign ones_s      = count_ones(keys);
    assign single_s    = (ones_s == 4'd1);
    assign multi_s     = (ones_s > 4'd1);
    assign cand_code_s = encode_key(cand_r);
    // Resulting tens digit would be the current secs digit
    assign shift_ok_s  = (secs_r <= 4'd5);

    // FSM state, debounce counter and candidate pattern registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            cand_r  <= 10'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            cand_r  <= cand_s;
        end
    end

    // Next-state logic: press debounce, hold lockout, release debounce
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cand_s   = cand_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (single_s && entry_en) begin
                    state_s = ST_PRESS_DB;
                    cand_s  = keys;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_PRESS_DB: begin
                if ((keys != cand_r) || !entry_en) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_HELD;
                    cnt_s    = CNT_ZERO;
                    accept_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (keys == 10'd0) begin
                    state_s = ST_RELEASE_DB;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_RELEASE_DB: begin
                if (keys != 10'd0) begin
                    state_s = ST_HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                cand_s  = 10'd0;
            end
        endcase
    end

    // Digit shift on accept; clear overrides a same-cycle accept
    always_comb begin
        secs_s     = secs_r;
        tens_s     = tens_r;
        mins_s     = mins_r;
        key_code_s = key_code_r;
        if (accept_s) begin
            key_code_s = cand_code_s;
        end else begin
            key_code_s = key_code_r;
        end
        if (clear) begin
            secs_s = 4'd0;
            tens_s = 4'd0;
            mins_s = 4'd0;
        end else if (accept_s && shift_ok_s) begin
            mins_s = tens_r;
            tens_s = secs_r;
            secs_s = cand_code_s;
        end else begin
            secs_s = secs_r;
            tens_s = tens_r;
            mins_s = mins_r;
        end
    end

    // Registered digit, code and accept-pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            secs_r      <= 4'd0;
            tens_r      <= 4'd0;
            mins_r      <= 4'd0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
        end else begin
            secs_r      <= secs_s;
            tens_r      <= tens_s;
            mins_r      <= mins_s;
            key_code_r  <= key_code_s;
            key_valid_r <= accept_s;
        end
    end

    assign secs      = secs_r;
    assign tens      = tens_r;
    assign mins      = mins_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;

`ifdef KEYPAD_ERR_EN
    logic multi_prev_r;
    logic key_err_r;
    logic err_s;

    // Error on refused shift, or on the first cycle of a multi-key press in idle
    always_comb begin
        err_s = 1'b0;
        if (accept_s && !shift_ok_s) begin
            err_s = 1'b1;
        end else if ((state_r == ST_IDLE) && multi_s && !multi_prev_r) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Registered error pulse and multi-key edge tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_prev_r <= 1'b0;
            key_err_r    <= 1'b0;
        end else begin
            multi_prev_r <= multi_s;
            key_err_r    <= err_s;
        end
    end

    assign key_err = key_err_r;
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_encoder
// Self-checking bench for keypad_encoder with DEBOUNCE_CYCLES = 4.
// The reference model works on whole key events. A press is accepted when
// it is a single key, entry is enabled, and it is held for at least
// DEBOUNCE_CYCLES+1 edges. The key_valid pulse then appears after edge
// DEBOUNCE_CYCLES+1 of the press. The time display is modelled as three
// integer digits shifted left.
// -----------------------------------------------------------------------------
module tb_keypad_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] keys;
    logic       clear;
    logic       entry_en;
    logic [3:0] secs, tens, mins, key_code;
    logic       key_valid;
`ifdef KEYPAD_ERR_EN
    logic       key_err;
`endif

    keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys      (keys),
        .clear     (clear),
        .entry_en  (entry_en),
        .secs      (secs),
        .tens      (tens),
        .mins      (mins),
        .key_valid (key_valid),
        .key_code  (key_code)
`ifdef KEYPAD_ERR_EN
        ,
        .key_err   (key_err)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the display and last accepted digit
    int m_secs = 0, m_tens = 0, m_mins = 0, m_code = 0;

    // Returns 1 when the shift is refused
    function automatic int model_accept(input int d);
        m_code = d;
        if (m_secs <= 5) begin
            m_mins = m_tens;
            m_tens = m_secs;
            m_secs = d;
            return 0;
        end
        return 1;
    endfunction

    task automatic model_clear();
        m_secs = 0;
        m_tens = 0;
        m_mins = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a pattern for 'hold' edges, then zero keys for 'gap' edges
    task automatic run_segment(input logic [9:0] pat, input int hold, input int gap,
                               input logic en, output int pulses, output int first_at,
                               output int errs);
        pulses   = 0;
        first_at = -1;
        errs     = 0;
        entry_en = en;
        keys     = pat;
        for (int j = 1; j <= hold + gap; j++) begin
            if (j == hold + 1) keys = 10'd0;
            step();
            if (key_valid === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = j;
            end
`ifdef KEYPAD_ERR_EN
            if (key_err === 1'b1) errs++;
`endif
        end
        entry_en = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; keys = 10'd0; clear = 1'b0; entry_en = 1'b1;
        #12;
        n_total++;
        if ({mins, tens, secs, key_code, key_valid} !== 17'd0)
            $display("FAIL reset_during: got %h exp 0", {mins, tens, secs, key_code, key_valid});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_total++;
        if ({mins, tens, secs, key_code, key_valid} !== 17'd0)
            $display("FAIL reset_after: got %h exp 0", {mins, tens, secs, key_code, key_valid});
        else n_pass++;
    endtask

    task automatic test_single_press();
        int p, f, e, r;
        run_segment(10'd1 << 5, 6, 10, 1'b1, p, f, e);
        r = model_accept(5);
        n_total++;
        if (p !== 1) $display("FAIL press5_pulses: got %0d exp 1", p); else n_pass++;
        n_total++;
        if (f !== D + 1) $display("FAIL press5_latency: got %0d exp %0d", f, D + 1); else n_pass++;
        n_total++;
        if ({mins, tens, secs, key_code} !== 16'h0055)
            $display("FAIL press5_digits: got %h exp 0055", {mins, tens, secs, key_code});
        else n_pass++;
    endtask

    task automatic test_sequence();
        int p, f, e, r;
        int digs[3] = '{1, 3, 0};
        do_clear();
        foreach (digs[i]) begin
            run_segment(10'd1 << digs[i], 7, 8, 1'b1, p, f, e);
            r = model_accept(digs[i]);
            n_total++;
            if (p !== 1) $display("FAIL seq_pulse%0d: got %0d exp 1", i, p); else n_pass++;
        end
        n_total++;
        if ({mins, tens, secs} !== 12'h130)
            $display("FAIL seq_130: got %h exp 130", {mins, tens, secs});
        else n_pass++;
    endtask

    task automatic test_reject();
        int p, f, e, r;
        do_clear();
        run_segment(10'd1 << 7, 6, 8, 1'b1, p, f, e);
        r = model_accept(7);
        run_segment(10'd1 << 2, 6, 8, 1'b1, p, f, e);
        r = model_accept(2);
        n_total++;
        if (p !== 1) $display("FAIL reject_pulse: got %0d exp 1", p); else n_pass++;
        n_total++;
        if ({mins, tens, secs, key_code} !== 16'h0072)
            $display("FAIL reject_digits: got %h exp 0072", {mins, tens, secs, key_code});
        else n_pass++;
`ifdef KEYPAD_ERR_EN
        n_total++;
        if (e !== 1) $display("FAIL reject_err: got %0d exp 1", e); else n_pass++;
`endif
    endtask

    task automatic test_bounce();
        int p;
        logic [3:0] pat_hi[5] = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
        p = 0;
        for (int j = 0; j < 15; j++) begin
            keys = (j < 5 && pat_hi[j] == 4'd1) ? (10'd1 << 4) : 10'd0;
            step();
            if (key_valid === 1'b1) p++;
        end
        n_total++;
        if (p !== 0) $display("FAIL bounce_pulses: got %0d exp 0", p); else n_pass++;
        n_total++;
        if ({mins, tens, secs} !== {4'(m_mins), 4'(m_tens), 4'(m_secs)})
            $display("FAIL bounce_digits: got %h exp %0d%0d%0d", {mins, tens, secs}, m_mins, m_tens, m_secs);
        else n_pass++;
    endtask

    task automatic test_hold_and_multi();
        int p, f, e, r;
        do_clear();
        run_segment(10'd1 << 8, 50, 8, 1'b1, p, f, e);
        r = model_accept(8);
        n_total++;
        if (p !== 1) $display("FAIL hold8_pulses: got %0d exp 1", p); else n_pass++;
        n_total++;
        if ({secs, key_code} !== 8'h88) $display("FAIL hold8_digit: got %h exp 88", {secs, key_code});
        else n_pass++;
        run_segment((10'd1 << 2) | (10'd1 << 3), 20, 8, 1'b1, p, f, e);
        n_total++;
        if (p !== 0) $display("FAIL multi_pulses: got %0d exp 0", p); else n_pass++;
        n_total++;
        if ({secs, key_code} !== 8'h88) $display("FAIL multi_digit: got %h exp 88", {secs, key_code});
        else n_pass++;
`ifdef KEYPAD_ERR_EN
        n_total++;
        if (e !== 1) $display("FAIL multi_err: got %0d exp 1", e); else n_pass++;
`endif
    endtask

    task automatic test_entry_disabled();
        int p, f, e;
        run_segment(10'd1 << 1, 10, 8, 1'b0, p, f, e);
        n_total++;
        if (p !== 0) $display("FAIL disabled_pulses: got %0d exp 0", p); else n_pass++;
        // entry_en drops partway through the press debounce
        p = 0;
        keys = 10'd1 << 1;
        for (int j = 1; j <= 16; j++) begin
            if (j == 3) entry_en = 1'b0;
            if (j == 9) keys = 10'd0;
            step();
            if (key_valid === 1'b1) p++;
        end
        entry_en = 1'b1;
        n_total++;
        if (p !== 0) $display("FAIL abort_pulses: got %0d exp 0", p); else n_pass++;
    endtask

    task automatic test_clear_accept();
        int p, f, e, r;
        run_segment(10'd1 << 3, 6, 8, 1'b1, p, f, e);
        r = model_accept(3);
        keys = 10'd1 << 9;
        for (int j = 1; j <= D; j++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_total++;
        if (key_valid !== 1'b1) $display("FAIL clracc_valid: got %b exp 1", key_valid); else n_pass++;
        n_total++;
        if ({mins, tens, secs, key_code} !== 16'h0009)
            $display("FAIL clracc_digits: got %h exp 0009", {mins, tens, secs, key_code});
        else n_pass++;
        keys = 10'd0;
        for (int j = 0; j < 8; j++) step();
        model_clear();
        m_code = 9;
    endtask

    task automatic test_reset_mid_press();
        int p, f, r;
        do_clear();
        run_segment(10'd1 << 6, 6, 8, 1'b1, p, f, r);
        r = model_accept(6);
        keys = 10'd1 << 7;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({mins, tens, secs, key_code, key_valid} !== 17'd0)
            $display("FAIL midreset_async: got %h exp 0", {mins, tens, secs, key_code, key_valid});
        else n_pass++;
        #1 rst_n = 1'b1;
        model_clear();
        m_code = 0;
        p = 0;
        f = -1;
        for (int j = 1; j <= 16; j++) begin
            if (j == 9) keys = 10'd0;
            step();
            if (key_valid === 1'b1) begin
                p++;
                if (f < 0) f = j;
            end
        end
        r = model_accept(7);
        n_total++;
        if (p !== 1 || f !== D + 1)
            $display("FAIL midreset_redebounce: got %0d pulses at %0d exp 1 at %0d", p, f, D + 1);
        else n_pass++;
        n_total++;
        if ({mins, tens, secs, key_code} !== 16'h0077)
            $display("FAIL midreset_digits: got %h exp 0077", {mins, tens, secs, key_code});
        else n_pass++;
    endtask

    task automatic test_random();
        int p, f, e, k1, k2, hold, gap, rej, exp_acc, exp_err;
        logic [9:0] pat;
        logic en, multi;
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 5) == 0) do_clear();
            k1    = int'($urandom_range(0, 9));
            multi = ($urandom_range(0, 3) == 0);
            pat   = 10'd1 << k1;
            if (multi) begin
                k2  = (k1 + int'($urandom_range(1, 9))) % 10;
                pat = pat | (10'd1 << k2);
            end
            hold    = int'($urandom_range(1, 8));
            gap     = int'($urandom_range(D + 2, D + 5));
            en      = ($urandom_range(0, 9) != 0);
            run_segment(pat, hold, gap, en, p, f, e);
            exp_acc = (!multi && en && hold >= D + 1) ? 1 : 0;
            rej     = 0;
            if (exp_acc == 1) rej = model_accept(k1);
            exp_err = (multi ? 1 : 0) + rej;
            n_total++;
            if (p !== exp_acc || (exp_acc == 1 && f !== D + 1))
                $display("FAIL rand%0d_pulse: got %0d at %0d exp %0d at %0d", s, p, f, exp_acc, D + 1);
            else n_pass++;
            n_total++;
            if ({mins, tens, secs, key_code} !== {4'(m_mins), 4'(m_tens), 4'(m_secs), 4'(m_code)})
                $display("FAIL rand%0d_state: got %h exp %0d%0d%0d code %0d", s,
                         {mins, tens, secs, key_code}, m_mins, m_tens, m_secs, m_code);
            else n_pass++;
`ifdef KEYPAD_ERR_EN
            n_total++;
            if (e !== exp_err) $display("FAIL rand%0d_err: got %0d exp %0d", s, e, exp_err);
            else n_pass++;
`else
            if (exp_err < 0) $display("unexpected error count");
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_sequence();
        test_reject();
        test_bounce();
        test_hold_and_multi();
        test_entry_disabled();
        test_clear_accept();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required to accept a press or a release.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port keys  input  10  raw key lines; bit k high = digit key k pressed.
REQ-005 SHALL have port clear  input  1  synchronous clear of the entered time.
REQ-006 SHALL have port entry_en  input  1  high = keypad entry allowed; low = presses ignored.
REQ-007 SHALL have port secs  output  4  BCD seconds-units digit.
REQ-008 SHALL have port tens  output  4  BCD seconds-tens digit, range 0-5.
REQ-009 SHALL have port mins  output  4  BCD minutes digit, range 0-9.
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse when a digit is accepted.
REQ-011 SHALL have port key_code  output  4  binary value of the last accepted digit.

Function
REQ-012 SHALL run an FSM with states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-013 IDLE -> PRESS_DB when exactly one keys bit is high and entry_en=1; the candidate code is latched and the debounce counter is cleared.
REQ-014 PRESS_DB: counter increments while keys equals the latched one-hot pattern; any change returns the FSM to IDLE with no effect.
REQ-015 PRESS_DB -> HELD when the counter reaches DEBOUNCE_CYCLES-1 with keys still stable; on this edge key_valid=1 for exactly one cycle and the digit shift of REQ-016 executes.
REQ-016 Shift on accept: mins<=tens, tens<=secs, secs<=key_code, applied only if the resulting tens is <=5; otherwise the digits are unchanged and key_valid is still pulsed.
REQ-017 HELD -> RELEASE_DB when keys==0; no new digit is accepted while in HELD, so auto-repeat is impossible.
REQ-018 RELEASE_DB -> IDLE after DEBOUNCE_CYCLES consecutive cycles with keys==0; any nonzero keys returns the FSM to HELD.
REQ-019 Two or more keys high simultaneously SHALL be ignored in IDLE; in PRESS_DB this is a pattern change and REQ-014 applies.
REQ-020 clear=1 SHALL zero secs, tens, and mins on the next edge, take priority over a same-cycle accept, and leave the FSM state untouched.
REQ-021 entry_en falling while in PRESS_DB SHALL abort to IDLE; HELD and RELEASE_DB proceed normally.
REQ-022 key_code SHALL hold its last accepted value until the next accept.
REQ-023 Latency: a clean press stable from cycle 0 SHALL raise key_valid in cycle DEBOUNCE_CYCLES+1.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, secs=tens=mins=0, key_code=0, and key_valid=0, independent of clk.
REQ-025 Reset asserted during PRESS_DB or HELD SHALL drop the pending key; after release, a still-held key SHALL be re-debounced from IDLE.

Configuration
REQ-026 With macro KEYPAD_ERR_EN defined, the block SHALL add output key_err (1 bit), pulsed for one cycle alongside key_valid when the REQ-016 shift is rejected, and also pulsed for one cycle when a multi-key pattern is seen in IDLE; key_err resets to 0.
REQ-027 Without KEYPAD_ERR_EN, the key_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, then press key 5 stable for 6 cycles and release -> key_valid single pulse in cycle 5; secs=5, tens=0, mins=0, key_code=5.
REQ-029 Enter keys 1, 3, 0 in sequence with full release between them -> mins=1, tens=3, secs=0 (the reference display 1:30).
REQ-030 With secs=7, press 2 -> shift rejected, digits unchanged, key_valid pulses; key_err pulses if KEYPAD_ERR_EN is defined.
REQ-031 Key 4 bouncing (high 2 cycles, low 1 cycle, high 2 cycles, low) -> no key_valid and digits unchanged.
REQ-032 Hold key 8 for 50 cycles -> exactly one key_valid; keys 2 and 3 pressed together -> no accept.
REQ-033 Assert clear in the same cycle as an accept -> all digits 0; rst_n pulsed low mid-PRESS_DB -> outputs 0 asynchronously and the key is re-debounced afterward.
